mdu_sequencer: RTL and testbench

//  Multi-cycle RV32M multiply/divide sequencer. Sits in execute beside the ALU and

---
 rtl/mdu_sequencer_pkg.sv | 43 ++++
 rtl/mdu_sequencer_if.sv | 25 ++
 rtl/mdu_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared execute-stage types: alu opcodes, RV32M opcodes and small decode helpers
// used by the multiply/divide sequencer.
package mdu_sequencer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_operation_t;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_operation_t;

  function automatic logic op_is_div(mdu_operation_t op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic lhs_signed(mdu_operation_t op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic rhs_signed(mdu_operation_t op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

  // Sign of the final result, from the original operand sign bits.
  function automatic logic result_negative(mdu_operation_t op, logic lhs_msb, logic rhs_msb);
    case (op)
      MDU_MULH, MDU_DIV:   return lhs_msb ^ rhs_msb;
      MDU_MULHSU, MDU_REM: return lhs_msb;
      default:             return 1'b0;
    endcase
  endfunction

  // MUL and quotients live in the low register, high products and remainders in the high one.
  function automatic logic result_in_lo(mdu_operation_t op);
    return op inside {MDU_MUL, MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response handshake bundle between the execute stage and the multiply/divide sequencer.
interface mdu_sequencer_if;
  import mdu_sequencer_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  mdu_operation_t        req_op;
  logic [XLEN-1:0]       req_lhs;
  logic [XLEN-1:0]       req_rhs;
  logic                  kill;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [XLEN-1:0]       resp_result;

  modport master (
    output req_valid, req_op, req_lhs, req_rhs, kill, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_lhs, req_rhs, kill, resp_ready,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/mdu_sequencer.sv
// RV32M sequencer over a shared alu: 33 cycles + one per operand negate + one sign fix (1 on divide-by-zero).
// Accepts only when idle; holds the result until resp_ready; kill aborts from any state.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mdu_sequencer_if.slave       bus,
  output alu_operation_t       alu_operation,
  output logic [XLEN-1:0]      alu_lhs,
  output logic [XLEN-1:0]      alu_rhs,
  input  logic [XLEN-1:0]      alu_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t          state_q, state_d;
  mdu_operation_t  op_q, op_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_b_q, neg_b_d;
  logic            fix_q, fix_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            div_zero;
  logic            req_neg_a;
  logic            req_neg_b;
  logic [XLEN-1:0] rem_shift;
  logic            ovf;
  logic            carry;
  logic            take;

  assign accept    = (state_q == S_IDLE) && bus.req_valid && !bus.kill;
  assign div_zero  = op_is_div(bus.req_op) && (bus.req_rhs == '0);
  assign req_neg_a = lhs_signed(bus.req_op) && bus.req_lhs[XLEN-1];
  assign req_neg_b = rhs_signed(bus.req_op) && bus.req_rhs[XLEN-1];

  // Divide step: remainder shifted up by one quotient bit; ovf catches the lost 33rd bit.
  assign rem_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign ovf       = hi_q[XLEN-1];
  assign take      = ovf || !(rem_shift < b_q);
  assign carry     = alu_result < alu_lhs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (div_zero)       state_d = S_DONE;
            else if (req_neg_a) state_d = S_NEG_A;
            else if (req_neg_b) state_d = S_NEG_B;
            else                state_d = S_ITER;
          end
        end
        S_NEG_A: state_d = neg_b_q ? S_NEG_B : S_ITER;
        S_NEG_B: state_d = S_ITER;
        S_ITER: begin
          if (cnt_q == CW'(XLEN - 1)) state_d = fix_q ? S_FIX : S_DONE;
        end
        S_FIX:  state_d = S_DONE;
        S_DONE: if (bus.resp_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_result = '0;
    alu_operation   = ALU_ADD;
    alu_lhs         = '0;
    alu_rhs         = '0;
    case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_NEG_A: begin
        alu_operation = ALU_SUB;
        alu_rhs       = lo_q;
      end
      S_NEG_B: begin
        alu_operation = ALU_SUB;
        alu_rhs       = b_q;
      end
      S_ITER: begin
        if (op_is_div(op_q)) begin
          alu_operation = ALU_SUB;
          alu_lhs       = rem_shift;
          alu_rhs       = b_q;
        end else begin
          alu_operation = ALU_ADD;
          alu_lhs       = hi_q;
          alu_rhs       = lo_q[0] ? b_q : '0;
        end
      end
      S_FIX: begin
        alu_operation = ALU_SUB;
        if (op_q inside {MDU_MULH, MDU_MULHSU}) begin
          // Upper word of the 64-bit negate: ~hi plus the borrow-free carry when lo is zero.
          alu_lhs = (lo_q == '0) ? '0 : '1;
          alu_rhs = hi_q;
        end else if (op_q == MDU_DIV) begin
          alu_rhs = lo_q;
        end else begin
          alu_rhs = hi_q;
        end
      end
      S_DONE: begin
        bus.resp_valid  = 1'b1;
        bus.resp_result = result_in_lo(op_q) ? lo_q : hi_q;
      end
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_b_d = neg_b_q;
    fix_d   = fix_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = bus.req_op;
          b_d     = bus.req_rhs;
          cnt_d   = '0;
          neg_b_d = req_neg_b;
          fix_d   = result_negative(bus.req_op, bus.req_lhs[XLEN-1], bus.req_rhs[XLEN-1]);
          if (div_zero) begin
            hi_d = bus.req_lhs;
            lo_d = '1;
          end else begin
            hi_d = '0;
            lo_d = bus.req_lhs;
          end
        end
      end
      S_NEG_A: lo_d = alu_result;
      S_NEG_B: b_d  = alu_result;
      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (op_is_div(op_q)) begin
          hi_d = take ? alu_result : rem_shift;
          lo_d = {lo_q[XLEN-2:0], take};
        end else begin
          {hi_d, lo_d} = {carry, alu_result, lo_q[XLEN-1:1]};
        end
      end
      S_FIX: begin
        if (op_q == MDU_DIV) lo_d = alu_result;
        else                 hi_d = alu_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MDU_MUL;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_b_q <= 1'b0;
      fix_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_b_q <= neg_b_d;
      fix_q   <= fix_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: reference results from 64-bit arithmetic, checked on each response.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if bus();

  alu_operation_t alu_operation;
  logic [31:0]    alu_lhs;
  logic [31:0]    alu_rhs;
  logic [31:0]    alu_result;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .alu_operation (alu_operation),
    .alu_lhs       (alu_lhs),
    .alu_rhs       (alu_rhs),
    .alu_result    (alu_result)
  );

  // Shared execute-stage alu
  always_comb begin
    case (alu_operation)
      ALU_ADD: alu_result = alu_lhs + alu_rhs;
      ALU_SUB: alu_result = alu_lhs - alu_rhs;
      ALU_AND: alu_result = alu_lhs & alu_rhs;
      ALU_OR:  alu_result = alu_lhs | alu_rhs;
      default: alu_result = alu_lhs ^ alu_rhs;
    endcase
  end

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rr_mode = 0;
  bit   in_resp = 0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(mdu_operation_t op, logic [31:0] l, logic [31:0] r);
    logic signed [63:0] sl;
    logic signed [63:0] sr;
    logic [63:0]        p;
    sl = $signed({{32{l[31]}}, l});
    sr = $signed({{32{r[31]}}, r});
    case (op)
      MDU_MUL:    begin p = {32'b0, l} * {32'b0, r}; return p[31:0]; end
      MDU_MULH:   begin p = sl * sr; return p[63:32]; end
      MDU_MULHSU: begin p = sl * $signed({32'b0, r}); return p[63:32]; end
      MDU_MULHU:  begin p = {32'b0, l} * {32'b0, r}; return p[63:32]; end
      MDU_DIV: begin
        if (r == 0) return 32'hFFFF_FFFF;
        if (l == 32'h8000_0000 && r == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sl / sr; return p[31:0];
      end
      MDU_DIVU:   return (r == 0) ? 32'hFFFF_FFFF : l / r;
      MDU_REM: begin
        if (r == 0) return l;
        if (l == 32'h8000_0000 && r == 32'hFFFF_FFFF) return 32'h0;
        p = sl % sr; return p[31:0];
      end
      default:    return (r == 0) ? l : l % r;
    endcase
  endfunction

  function automatic int ref_latency(mdu_operation_t op, logic [31:0] l, logic [31:0] r);
    int n;
    if (op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU} && r == 0) return 1;
    n = 33;
    if (op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM} && l[31]) n++;
    if (op inside {MDU_MULH, MDU_DIV, MDU_REM} && r[31]) n++;
    if (op inside {MDU_MULH, MDU_DIV} && (l[31] ^ r[31])) n++;
    if (op inside {MDU_MULHSU, MDU_REM} && l[31]) n++;
    return n;
  endfunction

  // Consumer backpressure: 0 random, 1 held low, 2 held high
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.resp_ready = ($urandom_range(0, 3) != 0);
      1:       bus.resp_ready = 1'b0;
      default: bus.resp_ready = 1'b1;
    endcase
  end

  // Monitor: pop on first sight of a response, recheck every cycle it is held
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 0;
    end else if (bus.resp_valid) begin
      if (!in_resp) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: resp_valid=1 result %h, want no response", bus.resp_result);
        end else begin
          cur = sb.pop_front();
          in_resp = 1;
          check({cur.name, "_latency"}, 32'(cyc - cur.acc + 1), 32'(cur.lat));
        end
      end
      if (in_resp) begin
        check(cur.name, bus.resp_result, cur.res);
        if (bus.resp_ready) in_resp = 0;
        else check("req_ready_while_done", 32'(bus.req_ready), 32'd0);
      end
    end
  end

  task automatic start(input mdu_operation_t op, input logic [31:0] l, input logic [31:0] r, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: req_ready=0 after 300 cycles, want 1");
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_lhs   = l;
    bus.req_rhs   = r;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (push) begin
      e.res  = ref_result(op, l, r);
      e.lat  = ref_latency(op, l, r);
      e.acc  = cyc;
      e.name = op.name();
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_resp) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0 || in_resp) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_result"}, bus.resp_result, 32'd0);
    check({tag, "_alu_op"}, 32'(alu_operation), 32'(ALU_ADD));
    check({tag, "_alu_lhs"}, alu_lhs, 32'd0);
    check({tag, "_alu_rhs"}, alu_rhs, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
    return $urandom;
  endfunction

  initial begin
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    bus.req_op    = MDU_MUL;
    bus.req_lhs   = '0;
    bus.req_rhs   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    start(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    start(MDU_MULH,   32'hFFFF_FFFE, 32'd3, 1);
    start(MDU_MUL,    32'hFFFF_FFFE, 32'd3, 1);
    start(MDU_DIV,    32'hFFFF_FFF9, 32'd2, 1);
    start(MDU_REM,    32'hFFFF_FFF9, 32'd2, 1);
    start(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1);
    start(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1);
    start(MDU_DIVU,   32'd100, 32'd0, 1);
    start(MDU_REMU,   32'd7, 32'd0, 1);
    start(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    drain();

    // Result held under backpressure
    rr_mode = 1;
    start(MDU_DIVU, 32'd100, 32'd7, 1);
    repeat (38) @(posedge clk);
    rr_mode = 2;
    drain();
    rr_mode = 0;

    // Kill during iteration
    start(MDU_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (9) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill_req_ready", 32'(bus.req_ready), 32'd1);
    check("kill_resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (40) @(posedge clk);

    // Kill together with a request in idle: not accepted
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = MDU_MUL;
    bus.kill      = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    check("kill_idle_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (40) @(posedge clk);

    // Reset in the middle of an operation
    start(MDU_DIV, 32'hFFFF_0000, 32'd3, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (60) begin
      start(mdu_operation_t'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
